lc3b_decode_stage: RTL

//   Pipelined LC-3b decode stage between fetch and execute. Holds one fetched instruction (ID register)
//   and decodes it into opcode, aluop, register indices, control bits and a pre-shifted/extended immediate.

---
 rtl/lc3b_decode_stage.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/lc3b_decode_stage.sv
// lc3b_decode_stage
//   LC-3b decode stage sitting between fetch and execute. One fetched
//   instruction is held in the ID register and decoded combinationally. The
//   decoded bundle is registered into the EX register, which drives execute
//   through a valid/ready handshake. A load followed by a dependent
//   instruction gets one bubble when LOAD_USE_STALL is set. flush drops
//   everything in flight.
// Ports
//   clk, rst            clock, synchronous active-high reset
//   if_valid/if_ready   fetch handshake, if_pc (PC+2) and if_ir (instruction)
//   flush               redirect, discards ID and EX contents
//   ex_valid/ex_ready   execute handshake
//   ex_*                registered decoded bundle (pc, opcode, aluop, register
//                       indices, immediate, control bits)
module lc3b_decode_stage #(
  parameter logic LOAD_USE_STALL = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  output logic        if_ready,
  input  logic [15:0] if_pc,
  input  logic [15:0] if_ir,
  input  logic        flush,
  output logic        ex_valid,
  input  logic        ex_ready,
  output logic [15:0] ex_pc,
  output logic [3:0]  ex_opcode,
  output logic [3:0]  ex_aluop,
  output logic [2:0]  ex_dest,
  output logic [2:0]  ex_src1,
  output logic [2:0]  ex_src2,
  output logic [15:0] ex_imm,
  output logic        ex_load_regfile,
  output logic        ex_load_cc,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_byte
);

  localparam logic [3:0] OP_BR   = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_LDB  = 4'd2;
  localparam logic [3:0] OP_STB  = 4'd3;
  localparam logic [3:0] OP_JSR  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_LDR  = 4'd6;
  localparam logic [3:0] OP_STR  = 4'd7;
  localparam logic [3:0] OP_NOT  = 4'd9;
  localparam logic [3:0] OP_LDI  = 4'd10;
  localparam logic [3:0] OP_STI  = 4'd11;
  localparam logic [3:0] OP_JMP  = 4'd12;
  localparam logic [3:0] OP_SHF  = 4'd13;
  localparam logic [3:0] OP_LEA  = 4'd14;
  localparam logic [3:0] OP_TRAP = 4'd15;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_AND = 4'd1;
  localparam logic [3:0] ALU_NOT = 4'd2;
  localparam logic [3:0] ALU_SLL = 4'd4;
  localparam logic [3:0] ALU_SRL = 4'd5;
  localparam logic [3:0] ALU_SRA = 4'd6;

  logic        id_valid;
  logic [15:0] id_pc;
  logic [15:0] id_ir;

  logic [3:0]  d_aluop;
  logic [2:0]  d_dest;
  logic [2:0]  d_src2;
  logic [15:0] d_imm;
  logic        d_load_regfile, d_load_cc, d_mem_read, d_mem_write, d_byte;
  logic        d_uses1, d_uses2;

  logic ex_adv, hazard, id_move, accept;

  always_comb begin
    d_aluop        = ALU_ADD;
    d_dest         = id_ir[11:9];
    d_src2         = id_ir[2:0];
    d_imm          = 16'h0000;
    d_load_regfile = 1'b0;
    d_load_cc      = 1'b0;
    d_mem_read     = 1'b0;
    d_mem_write    = 1'b0;
    d_byte         = 1'b0;
    d_uses1        = 1'b0;
    d_uses2        = 1'b0;
    case (id_ir[15:12])
      OP_ADD, OP_AND: begin
        d_uses1        = 1'b1;
        d_uses2        = ~id_ir[5];
        d_load_regfile = 1'b1;
        d_load_cc      = 1'b1;
        d_imm          = {{11{id_ir[4]}}, id_ir[4:0]};
        if (id_ir[15:12] == OP_AND) d_aluop = ALU_AND;
      end
      OP_NOT: begin
        d_uses1        = 1'b1;
        d_load_regfile = 1'b1;
        d_load_cc      = 1'b1;
        d_aluop        = ALU_NOT;
      end
      OP_SHF: begin
        d_uses1        = 1'b1;
        d_load_regfile = 1'b1;
        d_load_cc      = 1'b1;
        d_imm          = {12'h000, id_ir[3:0]};
        // ir[4] selects left/right, ir[5] arithmetic vs logical right shift
        if (!id_ir[4])     d_aluop = ALU_SLL;
        else if (!id_ir[5]) d_aluop = ALU_SRL;
        else               d_aluop = ALU_SRA;
      end
      OP_LDB, OP_LDR, OP_LDI: begin
        d_uses1        = 1'b1;
        d_load_regfile = 1'b1;
        d_load_cc      = 1'b1;
        d_mem_read     = 1'b1;
        d_byte         = (id_ir[15:12] == OP_LDB);
        if (id_ir[15:12] == OP_LDB)      d_imm = {{10{id_ir[5]}}, id_ir[5:0]};
        else if (id_ir[15:12] == OP_LDR) d_imm = {{9{id_ir[5]}}, id_ir[5:0], 1'b0};
        else                             d_imm = {{6{id_ir[8]}}, id_ir[8:0], 1'b0};
      end
      OP_STB, OP_STR, OP_STI: begin
        // stores read the data register from the dest field
        d_uses1     = 1'b1;
        d_uses2     = 1'b1;
        d_src2      = id_ir[11:9];
        d_mem_write = 1'b1;
        d_byte      = (id_ir[15:12] == OP_STB);
        if (id_ir[15:12] == OP_STB)      d_imm = {{10{id_ir[5]}}, id_ir[5:0]};
        else if (id_ir[15:12] == OP_STR) d_imm = {{9{id_ir[5]}}, id_ir[5:0], 1'b0};
        else                             d_imm = {{6{id_ir[8]}}, id_ir[8:0], 1'b0};
      end
      OP_BR: d_imm = {{6{id_ir[8]}}, id_ir[8:0], 1'b0};
      OP_LEA: begin
        d_load_regfile = 1'b1;
        d_load_cc      = 1'b1;
        d_imm          = {{6{id_ir[8]}}, id_ir[8:0], 1'b0};
      end
      OP_JSR: begin
        // ir[11]=1 is PC-relative JSR, ir[11]=0 is JSRR through BaseR
        d_dest         = 3'd7;
        d_load_regfile = 1'b1;
        d_uses1        = ~id_ir[11];
        if (id_ir[11]) d_imm = {{4{id_ir[10]}}, id_ir[10:0], 1'b0};
      end
      OP_TRAP: begin
        d_dest         = 3'd7;
        d_load_regfile = 1'b1;
        d_imm          = {7'h00, id_ir[7:0], 1'b0};
      end
      OP_JMP: d_uses1 = 1'b1;
      default: ;  // RTI behaves as a NOP
    endcase
  end

  assign ex_adv  = ~ex_valid | ex_ready;
  assign hazard  = LOAD_USE_STALL & ex_valid & ex_mem_read & ex_load_regfile & id_valid
                 & ((d_uses1 & (id_ir[8:6] == ex_dest)) | (d_uses2 & (d_src2 == ex_dest)));
  assign id_move  = id_valid & ex_adv & ~hazard;
  assign if_ready = ~rst & ~flush & (~id_valid | id_move);
  assign accept   = if_valid & if_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      id_valid        <= 1'b0;
      id_pc           <= 16'h0000;
      id_ir           <= 16'h0000;
      ex_valid        <= 1'b0;
      ex_pc           <= 16'h0000;
      ex_opcode       <= 4'h0;
      ex_aluop        <= 4'h0;
      ex_dest         <= 3'd0;
      ex_src1         <= 3'd0;
      ex_src2         <= 3'd0;
      ex_imm          <= 16'h0000;
      ex_load_regfile <= 1'b0;
      ex_load_cc      <= 1'b0;
      ex_mem_read     <= 1'b0;
      ex_mem_write    <= 1'b0;
      ex_byte         <= 1'b0;
    end else begin
      if (flush) begin
        id_valid <= 1'b0;
      end else if (accept) begin
        id_valid <= 1'b1;
        id_pc    <= if_pc;
        id_ir    <= if_ir;
      end else if (id_move) begin
        id_valid <= 1'b0;
      end

      if (flush)       ex_valid <= 1'b0;
      else if (ex_adv) ex_valid <= id_move;

      // fields follow the ID slot whenever EX advances; a bubble carries
      // the stalled instruction's decode with ex_valid low
      if (ex_adv) begin
        ex_pc           <= id_pc;
        ex_opcode       <= id_ir[15:12];
        ex_aluop        <= d_aluop;
        ex_dest         <= d_dest;
        ex_src1         <= id_ir[8:6];
        ex_src2         <= d_src2;
        ex_imm          <= d_imm;
        ex_load_regfile <= d_load_regfile;
        ex_load_cc      <= d_load_cc;
        ex_mem_read     <= d_mem_read;
        ex_mem_write    <= d_mem_write;
        ex_byte         <= d_byte;
      end
    end
  end

endmodule
